// File: rtl/bit_stuff_inserter_xl.sv
// rtl/bit_stuff_inserter_xl.sv - CAN XL transmit-side dynamic/fixed bit stuffer
//
// Purpose:
//    Takes unstuffed frame bits over a valid/ready handshake, one per bit-time
//    strobe, and drives the stuffed serial stream toward the TX pin driver.
//    Dynamic region: a complement bit follows every DYN_RUN equal driven bits.
//    Fixed region: a complement bit follows every FIX_PERIOD data bits, and the
//    first bit of the fixed region is itself a fixed stuff bit.
//
// Ports:
//    clk         system clock
//    g_rst       asynchronous active-low reset
//    frm_clr     synchronous start-of-frame clear (wins over bit_en)
//    bit_en      one-cycle strobe per bit time
//    dyn_stf_en  dynamic stuffing region active
//    fix_stf_en  fixed stuffing region active (wins over dyn_stf_en)
//    din         unstuffed frame bit
//    din_valid   din holds a valid bit
//    din_ready   din is consumed on this bit_en (low while a stuff bit is due)
//    tx_out      stuffed serial output, recessive (1) after reset
//    stf_bit     tx_out currently carries an inserted stuff bit
//    run_cnt     current equal-bit run length (dynamic region)
//    fix_cnt     data bits since the last fixed stuff bit (fixed region)
//    tx_bit_cnt  bits driven this frame including stuff bits, saturating
//    underrun    sticky: a data bit was due but din_valid was low

module bit_stuff_inserter_xl #(
   parameter int DYN_RUN    = 5,
   parameter int FIX_PERIOD = 10,
   parameter int CNT_W      = 15
) (
   input  logic             clk,
   input  logic             g_rst,
   input  logic             frm_clr,
   input  logic             bit_en,
   input  logic             dyn_stf_en,
   input  logic             fix_stf_en,
   input  logic             din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             tx_out,
   output logic             stf_bit,
   output logic [2:0]       run_cnt,
   output logic [3:0]       fix_cnt,
   output logic [CNT_W-1:0] tx_bit_cnt,
   output logic             underrun
);

   localparam logic [2:0] LP_DYN_RUN  = 3'(DYN_RUN);
   localparam logic [3:0] LP_FIX_LAST = 4'(FIX_PERIOD - 1);

   logic             r_tx_out;
   logic             r_stf_bit;
   logic [2:0]       r_run_cnt;
   logic [3:0]       r_fix_cnt;
   logic [CNT_W-1:0] r_tx_bit_cnt;
   logic             r_underrun;
   logic             r_stf_pend;
   logic             r_prev_fix;
   logic             r_prev_dyn;

   logic             w_fix_rise;
   logic             w_mode_fix;
   logic             w_mode_dyn;
   logic             w_drv_bit;
   logic [2:0]       w_run_next;
   logic             w_fix_wrap;
   logic             w_cnt_sat;

   // The mode applied to a bit is the one registered on the previous clock, so
   // a mode change coincident with bit_en only takes effect on the next bit.
   assign w_fix_rise = fix_stf_en & ~r_prev_fix;
   assign w_mode_fix = r_prev_fix;
   assign w_mode_dyn = r_prev_dyn & ~r_prev_fix;

   // tx_out doubles as last_bit: a stuff bit is the complement of the last
   // driven bit, and a missing data bit is filled with recessive.
   assign w_drv_bit  = r_stf_pend ? ~r_tx_out : (din_valid ? din : 1'b1);

   // A stuff bit always opens a new run of length one.
   assign w_run_next = (r_stf_pend || (w_drv_bit != r_tx_out)) ? 3'd1
                                                                : r_run_cnt + 3'd1;
   assign w_fix_wrap = (r_fix_cnt == LP_FIX_LAST);
   assign w_cnt_sat  = &r_tx_bit_cnt;

   always_ff @(posedge clk or negedge g_rst) begin
      if (!g_rst) begin
         r_tx_out     <= 1'b1;
         r_stf_bit    <= 1'b0;
         r_run_cnt    <= '0;
         r_fix_cnt    <= '0;
         r_tx_bit_cnt <= '0;
         r_underrun   <= 1'b0;
         r_stf_pend   <= 1'b0;
         r_prev_fix   <= 1'b0;
         r_prev_dyn   <= 1'b0;
      end else if (frm_clr) begin
         r_tx_out     <= 1'b1;
         r_stf_bit    <= 1'b0;
         r_run_cnt    <= '0;
         r_fix_cnt    <= '0;
         r_tx_bit_cnt <= '0;
         r_underrun   <= 1'b0;
         r_stf_pend   <= 1'b0;
         r_prev_fix   <= 1'b0;
         r_prev_dyn   <= 1'b0;
      end else begin
         r_prev_fix <= fix_stf_en;
         r_prev_dyn <= dyn_stf_en;

         if (bit_en) begin
            r_tx_out  <= w_drv_bit;
            r_stf_bit <= r_stf_pend;
            if (!r_stf_pend && !din_valid) begin
               r_underrun <= 1'b1;
            end
            if (!w_cnt_sat) begin
               r_tx_bit_cnt <= r_tx_bit_cnt + CNT_W'(1);
            end

            if (w_mode_fix) begin
               r_run_cnt <= '0;
               if (r_stf_pend) begin
                  // Stuff bits do not advance the fixed-period counter.
                  r_stf_pend <= 1'b0;
               end else if (w_fix_wrap) begin
                  r_fix_cnt  <= '0;
                  r_stf_pend <= 1'b1;
               end else begin
                  r_fix_cnt <= r_fix_cnt + 4'd1;
               end
            end else if (w_mode_dyn) begin
               r_fix_cnt  <= '0;
               r_run_cnt  <= w_run_next;
               r_stf_pend <= (w_run_next == LP_DYN_RUN);
            end else begin
               r_run_cnt  <= '0;
               r_fix_cnt  <= '0;
               r_stf_pend <= 1'b0;
            end
         end else if (!dyn_stf_en && !fix_stf_en) begin
            // Leaving stuffing altogether drops any stuff bit still owed.
            r_stf_pend <= 1'b0;
         end

         // Entering the fixed region always starts with a fixed stuff bit.
         if (w_fix_rise) begin
            r_stf_pend <= 1'b1;
            r_run_cnt  <= '0;
            r_fix_cnt  <= '0;
         end
      end
   end

   assign din_ready  = ~r_stf_pend;
   assign tx_out     = r_tx_out;
   assign stf_bit    = r_stf_bit;
   assign run_cnt    = r_run_cnt;
   assign fix_cnt    = r_fix_cnt;
   assign tx_bit_cnt = r_tx_bit_cnt;
   assign underrun   = r_underrun;

endmodule

// File: tb/tb_bit_stuff_inserter_xl.sv
// tb/tb_bit_stuff_inserter_xl.sv - self-checking bench for bit_stuff_inserter_xl

module tb_bit_stuff_inserter_xl;

   localparam int DYN_RUN    = 5;
   localparam int FIX_PERIOD = 10;
   localparam int CNT_W      = 15;

   logic             clk;
   logic             g_rst;
   logic             frm_clr;
   logic             bit_en;
   logic             dyn_stf_en;
   logic             fix_stf_en;
   logic             din;
   logic             din_valid;
   logic             din_ready;
   logic             tx_out;
   logic             stf_bit;
   logic [2:0]       run_cnt;
   logic [3:0]       fix_cnt;
   logic [CNT_W-1:0] tx_bit_cnt;
   logic             underrun;

   bit_stuff_inserter_xl #(
      .DYN_RUN(DYN_RUN), .FIX_PERIOD(FIX_PERIOD), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .g_rst(g_rst), .frm_clr(frm_clr), .bit_en(bit_en),
      .dyn_stf_en(dyn_stf_en), .fix_stf_en(fix_stf_en), .din(din),
      .din_valid(din_valid), .din_ready(din_ready), .tx_out(tx_out),
      .stf_bit(stf_bit), .run_cnt(run_cnt), .fix_cnt(fix_cnt),
      .tx_bit_cnt(tx_bit_cnt), .underrun(underrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: rule-level description of one clock of the stuffer.
   bit m_tx, m_stf, m_unr, m_pend, m_pfix, m_pdyn;
   int m_run, m_fix, m_cnt;

   task automatic model_reset();
      m_tx = 1; m_stf = 0; m_unr = 0; m_pend = 0; m_pfix = 0; m_pdyn = 0;
      m_run = 0; m_fix = 0; m_cnt = 0;
   endtask

   task automatic model_clk(input bit fc, input bit be, input bit dy, input bit fx,
                            input bit d, input bit v);
      int  mode;        // 0 none, 1 dynamic, 2 fixed
      bit  stuffing;
      bit  drv;
      if (fc) begin
         model_reset();
         return;
      end
      mode = m_pfix ? 2 : (m_pdyn ? 1 : 0);
      if (be) begin
         stuffing = m_pend;
         if (stuffing)  drv = !m_tx;
         else if (v)    drv = d;
         else begin
            drv   = 1;
            m_unr = 1;
         end
         m_pend = 0;
         case (mode)
            2: begin
               m_run = 0;
               if (!stuffing) begin
                  m_fix = m_fix + 1;
                  if (m_fix == FIX_PERIOD) begin
                     m_fix  = 0;
                     m_pend = 1;
                  end
               end
            end
            1: begin
               m_fix = 0;
               if (stuffing || drv != m_tx) m_run = 1;
               else                         m_run = m_run + 1;
               m_pend = (m_run == DYN_RUN);
            end
            default: begin
               m_run = 0;
               m_fix = 0;
            end
         endcase
         m_tx  = drv;
         m_stf = stuffing;
         if (m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
      end else if (!dy && !fx) begin
         m_pend = 0;
      end
      if (fx && !m_pfix) begin
         m_pend = 1;
         m_run  = 0;
         m_fix  = 0;
      end
      m_pfix = fx;
      m_pdyn = dy;
   endtask

   // Every cycle the registered outputs are compared against the model.
   always @(negedge clk) begin
      chk("cyc_tx_out",    tx_out,     m_tx);
      chk("cyc_stf_bit",   stf_bit,    m_stf);
      chk("cyc_run_cnt",   run_cnt,    m_run);
      chk("cyc_fix_cnt",   fix_cnt,    m_fix);
      chk("cyc_tx_bit_cnt", tx_bit_cnt, m_cnt);
      chk("cyc_underrun",  underrun,   m_unr);
      chk("cyc_din_ready", din_ready,  !m_pend);
   end

   bit         cur_dyn = 0;
   bit         cur_fix = 0;
   logic [31:0] seq;
   logic [31:0] sseq;
   int          nstf;

   // Called at posedge+1; returns at the next posedge+1 with the model updated.
   task automatic step(input bit fc, input bit be, input bit d, input bit v);
      frm_clr = fc; bit_en = be; dyn_stf_en = cur_dyn; fix_stf_en = cur_fix;
      din = d; din_valid = v;
      @(posedge clk);
      model_clk(fc, be, cur_dyn, cur_fix, d, v);
      #1;
   endtask

   task automatic send(input bit d, input bit v);
      step(0, 1, d, v);
      seq  = {seq[30:0], tx_out};
      sseq = {sseq[30:0], stf_bit};
      nstf = nstf + int'(stf_bit);
   endtask

   task automatic idle();
      step(0, 0, 0, 0);
   endtask

   task automatic clr();
      step(1, 0, 0, 0);
      seq = '0; sseq = '0; nstf = 0;
   endtask

   // Present n data bits MSB-first with valid held; stuff bits are absorbed.
   task automatic feed(input int n, input logic [31:0] pat);
      int idx = 0;
      int guard = 0;
      while (idx < n && guard < 2 * n + 8) begin
         if (din_ready) begin
            send(pat[n-1-idx], 1);
            idx++;
         end else begin
            send(pat[n-1-idx], 1);
         end
         guard++;
      end
      chk("feed_bound", idx, n);
   endtask

   initial begin
      frm_clr = 0; bit_en = 0; dyn_stf_en = 0; fix_stf_en = 0;
      din = 0; din_valid = 0; g_rst = 0;
      seq = '0; sseq = '0; nstf = 0;
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      g_rst = 1;

      chk("rst_tx_out", tx_out, 1);
      chk("rst_cnt", tx_bit_cnt, 0);
      chk("rst_ready", din_ready, 1);

      // Dynamic: 1,1,1,1,1,0 -> 1111100 with the stuff bit sixth.
      clr(); cur_dyn = 1; idle();
      feed(5, 32'b11111);
      chk("t1_ready_low", din_ready, 0);
      feed(1, 32'b0);
      chk("t1_seq", seq[6:0], 7'b1111100);
      chk("t1_stf", sseq[6:0], 7'b0000010);
      chk("t1_cnt", tx_bit_cnt, 7);

      // Dynamic: ten zeros -> 00000 1 00000, second stuff still pending.
      clr(); idle();
      feed(10, 32'b0);
      chk("t2_seq", seq[10:0], 11'b00000100000);
      chk("t2_cnt", tx_bit_cnt, 11);
      chk("t2_pend", din_ready, 0);

      // Enter fixed region with tx_out=0.
      clr(); idle();
      feed(1, 32'b0);
      cur_fix = 1; idle();
      chk("t3_rise_pend", din_ready, 0);
      send(0, 1);
      chk("t3_first_stf_tx", tx_out, 1);
      chk("t3_first_stf", stf_bit, 1);
      feed(10, 32'b1010101010);
      chk("t3_fix_wrap", fix_cnt, 0);
      send(1, 1);
      chk("t3_period_stf_tx", tx_out, 1);
      chk("t3_period_stf", stf_bit, 1);

      // Twelve ones in fixed region: one fixed stuff (0), no dynamic stuffing.
      seq = '0; nstf = 0;
      feed(12, 32'hFFF);
      chk("t4_seq", seq[12:0], 13'b1111111111011);
      chk("t4_nstf", nstf, 1);
      chk("t4_run", run_cnt, 0);

      // Underrun without a pending stuff bit, then with one.
      cur_fix = 0; cur_dyn = 0; clr(); idle();
      send(0, 0);
      chk("t5_unr_tx", tx_out, 1);
      chk("t5_unr", underrun, 1);
      send(0, 1);
      chk("t5_unr_sticky", underrun, 1);
      cur_dyn = 1; clr(); idle();
      feed(5, 32'b11111);
      send(0, 0);
      chk("t5_stf_tx", tx_out, 0);
      chk("t5_stf", stf_bit, 1);
      chk("t5_no_unr", underrun, 0);

      // Asynchronous reset mid-run.
      clr(); idle();
      feed(4, 32'b1111);
      chk("t6_run4", run_cnt, 4);
      #2 g_rst = 0;
      model_reset();
      #1;
      chk("t6_rst_tx", tx_out, 1);
      chk("t6_rst_run", run_cnt, 0);
      chk("t6_rst_cnt", tx_bit_cnt, 0);
      chk("t6_rst_ready", din_ready, 1);
      #2 g_rst = 1;
      idle();
      seq = '0; sseq = '0; nstf = 0;
      feed(5, 32'b11111);
      send(1, 1);
      chk("t6_nstf", nstf, 1);
      chk("t6_stf_tx", tx_out, 0);

      // Randomised traffic with mode changes, clears and underruns.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 39) == 0) cur_dyn = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 59) == 0) cur_fix = 1'($urandom_range(0, 1));
         step(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0));
      end

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
